// File: rtl/dmem_if.sv
// Load/store request bus between the memory stage (master) and the
// data-memory responder (slave).
interface dmem_if;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        input  busy, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        output busy, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word request at a time,
// stalls the pipeline for LATENCY wait cycles, then pulses a response.
// Misaligned or read+write requests complete with an error and never
// touch the array.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [31:0]       mem [0:(2**ADDR_W)-1];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              isRead_q, isRead_d;
    logic              isWrite_q, isWrite_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addrIdx_q, addrIdx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              respValid_q, respValid_d;
    logic              respErr_q, respErr_d;
    logic [31:0]       respRdata_q, respRdata_d;

    logic              req;
    logic              reqErr;
    logic              accessNow;
    logic              accRead;
    logic              accWrite;
    logic              accErr;
    logic [ADDR_W-1:0] accIdx;
    logic [31:0]       accWdata;
    logic              unusedAddrBits;

    assign req    = bus.req_read | bus.req_write;
    assign reqErr = (bus.req_addr[1:0] != 2'b00) | (bus.req_read & bus.req_write);
    assign unusedAddrBits = &{1'b0, bus.req_addr};

    // Pick the operands for the access edge: live inputs on a zero-latency
    // accept straight from IDLE, otherwise the copies latched at accept time.
    always_comb begin
        accessNow = 1'b0;
        accRead   = isRead_q;
        accWrite  = isWrite_q;
        accErr    = err_q;
        accIdx    = addrIdx_q;
        accWdata  = wdata_q;
        if (state_q == IDLE) begin
            accessNow = (LATENCY == 0) && req;
            accRead   = bus.req_read;
            accWrite  = bus.req_write;
            accErr    = reqErr;
            accIdx    = bus.req_addr[ADDR_W+1:2];
            accWdata  = bus.req_wdata;
        end else if (state_q == WAIT) begin
            accessNow = (cnt_q == 4'd0);
        end
    end

    // Next-state logic for the IDLE/WAIT/RESP sequencer and response registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        isRead_d    = isRead_q;
        isWrite_d   = isWrite_q;
        err_d       = err_q;
        addrIdx_d   = addrIdx_q;
        wdata_d     = wdata_q;
        respValid_d = 1'b0;
        respErr_d   = respErr_q;
        respRdata_d = respRdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    isRead_d  = bus.req_read;
                    isWrite_d = bus.req_write;
                    err_d     = reqErr;
                    addrIdx_d = bus.req_addr[ADDR_W+1:2];
                    wdata_d   = bus.req_wdata;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accessNow) begin
            respValid_d = 1'b1;
            respErr_d   = accErr;
            if (!accErr && accRead) begin
                respRdata_d = mem[accIdx];
            end
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            isRead_q    <= 1'b0;
            isWrite_q   <= 1'b0;
            err_q       <= 1'b0;
            addrIdx_q   <= '0;
            wdata_q     <= 32'd0;
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            respRdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            isRead_q    <= isRead_d;
            isWrite_q   <= isWrite_d;
            err_q       <= err_d;
            addrIdx_q   <= addrIdx_d;
            wdata_q     <= wdata_d;
            respValid_q <= respValid_d;
            respErr_q   <= respErr_d;
            respRdata_q <= respRdata_d;
        end
    end

    // Array write on the access edge; a reset on that edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && accessNow && accWrite && !accErr) begin
            mem[accIdx] <= accWdata;
        end
    end

    assign bus.busy       = ((state_q == IDLE) && req) || (state_q == WAIT);
    assign bus.resp_valid = respValid_q;
    assign bus.resp_err   = respErr_q;
    assign bus.resp_rdata = respRdata_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the memory-stage side of the pipeline: the responder end of the load/store request interface. Accepts one word-aligned read or write request at a time, holds the pipeline via `busy` for a programmable access latency, then returns read data or write completion with a one-cycle `resp_valid`. Replaces the single-cycle data array when modelling slower memory; flags misaligned or conflicting requests without touching the array.

## Interface
- `ADDR_W`, 8: word-index width; the array holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: number of WAIT cycles between request acceptance and the access edge; legal range 0–15.

Reset is synchronous and active-high, sampled on the rising edge of `clk`.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_read`  in  1  load request (the stage's MEM_read).
- `req_write`  in  1  store request (the stage's MEM_write).
- `req_addr`  in  32  byte address (the ALU result).
- `req_wdata`  in  32  store data.
- `busy`  out  1  stall request to the pipeline.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load data; valid when `resp_valid` is high for a read.
- `resp_err`  out  1  error flag, qualified by `resp_valid`.

## Operation
- **States:** IDLE, WAIT, RESP. Counter `cnt` is 4 bits.
- **Request:** `req = req_read | req_write`.
- **IDLE, `req` high:**
  - Latch the read flag, write flag, address and wdata into internal registers.
  - Compute `err = (req_addr[1:0] != 0) | (req_read & req_write)`.
  - If `LATENCY == 0`, go to RESP. Otherwise load `cnt = LATENCY-1` and go to WAIT.
- **WAIT:**
  - If `cnt == 0`, go to RESP; otherwise decrement `cnt`.
  - Inputs are ignored; the latched copies are used.
- **Access edge:** the edge entering RESP. On this edge, when the latched `err` is 0:
  - Write: `mem[addr[ADDR_W+1:2]] <= wdata`.
  - Read: `resp_rdata <= mem[addr[ADDR_W+1:2]]`.
  - `err == 1`: no array access and `resp_rdata` keeps its value.
- **RESP:** `resp_valid = 1`, `resp_err` = latched `err`. Next state is always IDLE, so no new request is accepted in RESP.
- **`busy`:** combinational, `(state==IDLE & req) | (state==WAIT)`. It is low in RESP, which releases the pipeline.
- **Address range:** address bits above `ADDR_W+1` are ignored, so out-of-range addresses alias modulo the array size. This is not an error.
- **Write response:** `resp_rdata` is unchanged on writes.
- **Requester rule:** hold the request until the `resp_valid` cycle. A request still asserted in IDLE after RESP is treated as a new request.

## Timing
- Request first seen in IDLE at cycle 0:
  - `busy` is high in cycles 0..LATENCY.
  - `resp_valid` is high in cycle LATENCY+1 only.
  - Total occupancy is LATENCY+2 cycles per access, including the RESP cycle.
- **Back-to-back:** minimum spacing between acceptances is LATENCY+2 cycles.
- **Reset values (registered):** state=IDLE, `cnt`=0, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0. `busy` is combinational and low in IDLE while no request is presented.
- **Array:** contents are not reset.
- **Reset mid-operation:**
  - `rst` in IDLE or WAIT (before the access edge): the transaction is dropped, no write occurs and no response is issued.
  - `rst` in RESP: the array write has already taken place, and `resp_valid` clears on the next edge.
- **Simultaneous `rst` and `req`:** `rst` wins and the request is not latched.
- **Read-after-write:** a read issued after a write's RESP cycle to the same word returns the new data.

## Test plan
1. **Reset defaults:** reset, then idle 5 cycles -> `busy`=0, `resp_valid`=0, `resp_rdata`=0 every cycle.
2. **Write then read, LATENCY=2:**
   - Write 0xDEADBEEF to address 0x10 -> `busy` high for 3 cycles, `resp_valid` in cycle 3.
   - Then read address 0x10 -> `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` in cycle 3 of the read.
3. **Aliasing, ADDR_W=8:** write 0x12345678 to address 0x400, read address 0x000 -> 0x12345678.
4. **Error responses:**
   - Write 0x1 to address 0x13 -> `resp_err`=1; a subsequent read of address 0x10 returns the prior value.
   - Read with `req_write` also set -> `resp_err`=1, `resp_rdata` unchanged.
5. **Reset mid-write:** assert `rst` in the WAIT cycle of a write of 0xA5A5A5A5 to address 0x20 -> no `resp_valid`; a read of address 0x20 returns the old contents.
6. **LATENCY=0:**
   - Read -> `busy` high 1 cycle, `resp_valid` in cycle 1.
   - Request held through RESP -> re-accepted in cycle 2, second `resp_valid` in cycle 3.
